// File: rtl/vdp1_fb_line_reader.sv
// Scan-out engine for one VDP1 framebuffer bank: line request -> sequential reads -> pixel stream.
// Latency: first pixel valid 3 cycles after LINE_REQ; then 1 pixel/cycle with continuous grant and ready.
// Backpressure: reads are credit-limited by FIFO room, so a stalled consumer throttles reads.

module vdp1_fb_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

module vdp1_fb_line_reader #(
    parameter int FB_WORDS   = 90112,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LINE_REQ,
    input  logic [8:0]  LINE_Y,
    input  logic [9:0]  LINE_STRIDE,
    input  logic [9:0]  LINE_LEN,
    input  logic        LINE_ABORT,
    output logic [16:0] FB_ADDR,
    output logic        FB_RD,
    input  logic        FB_GNT,
    input  logic [15:0] FB_Q,
    output logic [15:0] PIX_DATA,
    output logic        PIX_VALID,
    input  logic        PIX_READY,
    output logic        PIX_LAST,
    output logic        BUSY,
    output logic        LINE_DONE
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [19:0] ADDR_LIMIT = 20'(FB_WORDS);
    localparam logic [CW:0] DEPTH_W    = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [19:0]   addr;
    logic [10:0]   issue_cnt;
    logic [10:0]   out_cnt;
    logic [10:0]   req_len;
    logic          inflight;
    logic          line_done_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic [15:0]   fifo_head;

    logic          abort_now;
    logic          credit_ok;
    logic          in_range;
    logic          want_slot;
    logic          rd_gnt;
    logic          zero_push;
    logic          ret_push;
    logic          push_vld;
    logic [15:0]   push_dat;
    logic          pop;
    logic          last_pop;
    logic          slot_used;

    assign req_len   = (LINE_LEN == 10'd0) ? 11'd1024 : {1'b0, LINE_LEN};
    assign abort_now = LINE_ABORT && (state != IDLE);
    assign credit_ok = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight}) < DEPTH_W;
    assign in_range  = (addr < ADDR_LIMIT);
    assign want_slot = (state == FETCH) && (issue_cnt != 11'd0) && credit_ok && !abort_now;
    assign FB_RD     = want_slot && in_range;
    assign rd_gnt    = FB_RD && FB_GNT;
    // A zero fill waits for any read return so the two never collide on the FIFO write port.
    assign zero_push = want_slot && !in_range && !inflight;
    assign ret_push  = inflight && !abort_now;
    assign push_vld  = ret_push || zero_push;
    assign push_dat  = ret_push ? FB_Q : 16'h0000;
    assign slot_used = rd_gnt || zero_push;

    assign PIX_VALID = !fifo_empty;
    assign PIX_DATA  = PIX_VALID ? fifo_head : 16'h0000;
    assign PIX_LAST  = PIX_VALID && (out_cnt == 11'd1);
    assign pop       = PIX_VALID && PIX_READY && !abort_now;
    assign last_pop  = pop && (out_cnt == 11'd1);
    assign FB_ADDR   = addr[16:0];
    assign LINE_DONE = line_done_q;

    vdp1_fb_fifo #(
        .W     (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .flush    (abort_now),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        BUSY      = (state != IDLE);
        case (state)
            IDLE: begin
                if (LINE_REQ) state_nxt = FETCH;
            end
            FETCH: begin
                if (abort_now)                                 state_nxt = IDLE;
                else if (slot_used && (issue_cnt == 11'd1))    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort_now || last_pop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr        <= '0;
            issue_cnt   <= '0;
            out_cnt     <= '0;
            inflight    <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            line_done_q <= last_pop;
            // A forced-low FB_RD during abort means no new read goes in flight.
            inflight    <= rd_gnt;
            if ((state == IDLE) && LINE_REQ) begin
                addr      <= {1'b0, 19'(LINE_Y) * 19'(LINE_STRIDE)};
                issue_cnt <= req_len;
                out_cnt   <= req_len;
            end else begin
                if (slot_used) begin
                    addr      <= addr + 20'd1;
                    issue_cnt <= issue_cnt - 11'd1;
                end
                if (pop) out_cnt <= out_cnt - 11'd1;
            end
        end
    end
endmodule

// File: tb/tb_vdp1_fb_line_reader.sv
// Scoreboard bench for vdp1_fb_line_reader: expected pixels/addresses are queued at request time.
module tb_vdp1_fb_line_reader;
    localparam int FBW   = 90112;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LINE_REQ = 1'b0;
    logic [8:0]  LINE_Y = '0;
    logic [9:0]  LINE_STRIDE = '0;
    logic [9:0]  LINE_LEN = '0;
    logic        LINE_ABORT = 1'b0;
    logic [16:0] FB_ADDR;
    logic        FB_RD;
    logic        FB_GNT = 1'b1;
    logic [15:0] FB_Q = '0;
    logic [15:0] PIX_DATA;
    logic        PIX_VALID;
    logic        PIX_READY = 1'b1;
    logic        PIX_LAST;
    logic        BUSY;
    logic        LINE_DONE;

    vdp1_fb_line_reader #(.FB_WORDS(FBW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .LINE_REQ(LINE_REQ), .LINE_Y(LINE_Y),
        .LINE_STRIDE(LINE_STRIDE), .LINE_LEN(LINE_LEN), .LINE_ABORT(LINE_ABORT),
        .FB_ADDR(FB_ADDR), .FB_RD(FB_RD), .FB_GNT(FB_GNT), .FB_Q(FB_Q),
        .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .PIX_LAST(PIX_LAST), .BUSY(BUSY), .LINE_DONE(LINE_DONE)
    );

    always #5 CLK = ~CLK;

    logic [15:0] ram [FBW];
    always @(posedge CLK) begin
        if (FB_RD && FB_GNT) FB_Q <= (FB_ADDR < FBW) ? ram[FB_ADDR] : 16'hDEAD;
    end

    typedef struct packed { logic [15:0] d; logic last; } pix_t;
    pix_t        exp_pix [$];
    logic [16:0] exp_addr [$];

    int n_checks = 0;
    int n_pass   = 0;
    int grants_line = 0, acc_line = 0, grants_total = 0;
    int gnt_mode = 0, rdy_mode = 0;
    logic        done_due = 1'b0, prev_wait = 1'b0;
    logic [16:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // Grant/ready pattern generator: 0 = always high, 1 = toggle/always low, 2 = random.
    always @(posedge CLK) begin
        #1;
        case (gnt_mode)
            0: FB_GNT = 1'b1;
            1: FB_GNT = ~FB_GNT;
            default: FB_GNT = 1'($urandom_range(0, 1));
        endcase
        case (rdy_mode)
            0: PIX_READY = 1'b1;
            1: PIX_READY = 1'b0;
            default: PIX_READY = ($urandom_range(0, 9) < 7);
        endcase
    end

    // Monitor: compares every granted read and every accepted pixel against the queues.
    always @(negedge CLK) begin
        if (RST) begin
            done_due  = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (done_due) begin
                check("line_done_pulse", LINE_DONE, 1);
                check("busy_after_done", BUSY, 0);
                done_due = 1'b0;
            end else if (LINE_DONE) begin
                fail("spurious_line_done");
            end
            if (!LINE_ABORT) begin
                if (FB_RD && FB_GNT) begin
                    if (exp_addr.size() == 0) fail("unexpected_read");
                    else check("fb_addr", FB_ADDR, exp_addr.pop_front());
                    grants_line++;
                    grants_total++;
                    check("credit_limit", (grants_line - acc_line) <= DEPTH, 1);
                end
                if (PIX_VALID && PIX_READY) begin
                    if (exp_pix.size() == 0) fail("unexpected_pixel");
                    else begin
                        pix_t p;
                        p = exp_pix.pop_front();
                        check("pix_data", PIX_DATA, p.d);
                        check("pix_last", PIX_LAST, p.last);
                        if (p.last) done_due = 1'b1;
                    end
                    acc_line++;
                end
            end
            if (prev_wait && FB_RD) check("addr_hold", FB_ADDR, prev_addr);
            prev_wait = FB_RD && !FB_GNT;
            prev_addr = FB_ADDR;
        end
    end

    // Reference model: pixel i of a line is ram[y*stride+i], or zero past the bank end.
    task automatic start_line(input int y, input int stride, input int len);
        int lenx, base, a;
        lenx = (len == 0) ? 1024 : len;
        base = y * stride;
        @(posedge CLK);
        #1;
        LINE_Y = 9'(y);
        LINE_STRIDE = 10'(stride);
        LINE_LEN = 10'(len);
        LINE_REQ = 1'b1;
        grants_line = 0;
        acc_line = 0;
        for (int i = 0; i < lenx; i++) begin
            a = base + i;
            if (a < FBW) begin
                exp_addr.push_back(17'(a));
                exp_pix.push_back({ram[a], i == lenx - 1});
            end else begin
                exp_pix.push_back({16'h0000, i == lenx - 1});
            end
        end
        @(posedge CLK);
        #1;
        LINE_REQ = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while ((BUSY || exp_pix.size() != 0) && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check("line_complete", {30'd0, BUSY, exp_pix.size() == 0}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fb_rd"}, FB_RD, 0);
        check({tag, "_fb_addr"}, FB_ADDR, 0);
        check({tag, "_pix_valid"}, PIX_VALID, 0);
        check({tag, "_pix_last"}, PIX_LAST, 0);
        check({tag, "_pix_data"}, PIX_DATA, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_line_done"}, LINE_DONE, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, k;
        for (int i = 0; i < FBW; i++) ram[i] = 16'($urandom);

        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("post_reset");

        // Stream with exact cycle timing.
        gnt_mode = 0; rdy_mode = 0;
        start_line(2, 352, 4);
        @(negedge CLK);
        @(negedge CLK);
        check("first_valid_early", PIX_VALID, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("stream_valid", PIX_VALID, 1);
        end
        @(negedge CLK);
        check("stream_done", LINE_DONE, 1);
        check("stream_busy", BUSY, 0);
        wait_done(50);

        // Backpressure: consumer stalled while reads fill the FIFO.
        rdy_mode = 1;
        g0 = grants_total;
        start_line(3, 512, 16);
        repeat (10) @(negedge CLK);
        check("stall_grants", grants_total - g0, DEPTH);
        rdy_mode = 0;
        wait_done(200);

        // Grant starvation.
        gnt_mode = 1;
        start_line(2, 352, 4);
        wait_done(100);

        // Bank boundary: last valid row, then the first row past the end.
        gnt_mode = 2; rdy_mode = 2;
        start_line(255, 352, 352);
        wait_done(5000);
        start_line(256, 352, 352);
        wait_done(5000);
        check("oor_no_reads", grants_line, 0);
        start_line(254, 354, 300);
        wait_done(5000);

        // Abort after 5 accepted pixels.
        gnt_mode = 0; rdy_mode = 0;
        start_line(10, 352, 100);
        k = 0;
        while (acc_line < 5 && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check("abort_reach_5", acc_line >= 5, 1);
        @(posedge CLK);
        #1 LINE_ABORT = 1'b1;
        @(negedge CLK);
        check("abort_fb_rd", FB_RD, 0);
        @(posedge CLK);
        #1 LINE_ABORT = 1'b0;
        exp_pix.delete();
        exp_addr.delete();
        @(negedge CLK);
        check("abort_valid", PIX_VALID, 0);
        check("abort_busy", BUSY, 0);
        repeat (4) @(negedge CLK);
        start_line(7, 352, 20);
        wait_done(200);

        // Reset during FETCH, then a 1024-word line.
        gnt_mode = 2; rdy_mode = 2;
        start_line(5, 400, 200);
        repeat (8) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        exp_pix.delete();
        exp_addr.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        start_line(0, 512, 0);
        wait_done(10000);

        // Randomized lines.
        for (int r = 0; r < 10; r++) begin
            gnt_mode = $urandom_range(0, 2);
            rdy_mode = (r % 3 == 0) ? 0 : 2;
            start_line($urandom_range(0, 260), $urandom_range(100, 400), $urandom_range(1, 80));
            wait_done(3000);
        end

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
